// File: rtl/change_dispenser.sv
// change_dispenser
//
// Pays out an exact change amount one coin at a time using a greedy
// largest-coin-first choice over four denominations (1, 5, 10, 50), each
// backed by a saturating stock counter. A request is accepted in IDLE,
// coins are presented to a hopper one by one, and the transaction ends with
// either a one-cycle done pulse or a one-cycle error pulse (with the unpaid
// remainder reported on shortfall).
//
// Handshake: coin_valid/coin_type are held stable while coin_valid is high;
// a coin is transferred on a rising edge where coin_valid && coin_ack. coin_ack
// is ignored whenever coin_valid is low.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, change_amt   payout request (sampled only in IDLE)
//   coin_ack            hopper has taken the presented coin
//   refill, refill_type, refill_qty   add coins to one stock counter (any state)
//   busy                high whenever not IDLE
//   coin_valid, coin_type   presented coin (00=1, 01=5, 10=10, 11=50)
//   done, error         one-cycle completion / failure pulses
//   paid_total          value of coins acknowledged in the current transaction
//   shortfall           unpaid remainder after an error, else 0
//   dbg_state_o         current FSM state encoding
module change_dispenser #(
    parameter int STOCK_W    = 8,
    parameter int STOCK_INIT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [31:0]        change_amt,
    input  logic               coin_ack,
    input  logic               refill,
    input  logic [1:0]         refill_type,
    input  logic [STOCK_W-1:0] refill_qty,
    output logic               busy,
    output logic               coin_valid,
    output logic [1:0]         coin_type,
    output logic               done,
    output logic               error,
    output logic [31:0]        paid_total,
    output logic [31:0]        shortfall,
    output logic [2:0]         dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_ISSUE  = 3'd2,
        S_DONE   = 3'd3,
        S_FAIL   = 3'd4
    } state_t;

    localparam logic [STOCK_W-1:0] STOCK_MAX = {STOCK_W{1'b1}};

    function automatic logic [31:0] coin_value(input logic [1:0] d);
        case (d)
            2'd0:    coin_value = 32'd1;
            2'd1:    coin_value = 32'd5;
            2'd2:    coin_value = 32'd10;
            default: coin_value = 32'd50;
        endcase
    endfunction

    state_t             state_q, state_d;
    logic [31:0]        rem_q, rem_d;
    logic [1:0]         sel_q, sel_d;
    logic [31:0]        paid_q, paid_d;
    logic [31:0]        short_q, short_d;
    logic [STOCK_W-1:0] stk_q [4];
    logic [STOCK_W-1:0] stk_d [4];
    logic [STOCK_W:0]   stk_sum [4];

    logic       pick_found;
    logic [1:0] pick_d;
    logic       take;

    // Greedy choice: scanning upward lets the largest eligible coin win.
    always_comb begin
        pick_found = 1'b0;
        pick_d     = 2'd0;
        for (int d = 0; d < 4; d++) begin
            if (coin_value(2'(d)) <= rem_q && stk_q[d] != '0) begin
                pick_found = 1'b1;
                pick_d     = 2'(d);
            end
        end
    end

    assign take = (state_q == S_ISSUE) && coin_ack;

    // Refill and an accepted coin of the same type both apply in one cycle.
    // The extra sum bit catches overflow for saturation; the decrement never
    // underflows because a coin is only selected while its stock is nonzero.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            stk_sum[i] = {1'b0, stk_q[i]};
            if (refill && refill_type == 2'(i)) begin
                stk_sum[i] = stk_sum[i] + {1'b0, refill_qty};
            end
            if (take && sel_q == 2'(i)) begin
                stk_sum[i] = stk_sum[i] - 1'b1;
            end
            stk_d[i] = stk_sum[i][STOCK_W] ? STOCK_MAX : stk_sum[i][STOCK_W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        sel_d   = sel_q;
        paid_d  = paid_q;
        short_d = short_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_d   = change_amt;
                    paid_d  = 32'd0;
                    short_d = 32'd0;
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (rem_q == 32'd0) begin
                    state_d = S_DONE;
                end else if (pick_found) begin
                    sel_d   = pick_d;
                    state_d = S_ISSUE;
                end else begin
                    short_d = rem_q;
                    state_d = S_FAIL;
                end
            end
            S_ISSUE: begin
                if (coin_ack) begin
                    rem_d   = rem_q - coin_value(sel_q);
                    paid_d  = paid_q + coin_value(sel_q);
                    state_d = S_SELECT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rem_q   <= 32'd0;
            sel_q   <= 2'd0;
            paid_q  <= 32'd0;
            short_q <= 32'd0;
            for (int i = 0; i < 4; i++) begin
                stk_q[i] <= STOCK_W'(STOCK_INIT);
            end
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            sel_q   <= sel_d;
            paid_q  <= paid_d;
            short_q <= short_d;
            for (int i = 0; i < 4; i++) begin
                stk_q[i] <= stk_d[i];
            end
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign coin_valid  = (state_q == S_ISSUE);
    assign coin_type   = (state_q == S_ISSUE) ? sel_q : 2'd0;
    assign done        = (state_q == S_DONE);
    assign error       = (state_q == S_FAIL);
    assign paid_total  = paid_q;
    assign shortfall   = short_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: two instances (default stock, and stock of 1),
// a table of payout transactions, and hand-written hold/refill/reset cases.
module tb_change_dispenser;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic [31:0] change_amt = 32'd0;
    logic        coin_ack = 1'b1;
    logic        refill = 1'b0;
    logic [1:0]  refill_type = 2'd0;
    logic [7:0]  refill_qty = 8'd0;

    logic        bz0, cv0, dn0, er0, bz1, cv1, dn1, er1;
    logic [1:0]  ct0, ct1;
    logic [31:0] pt0, sf0, pt1, sf1;
    logic [2:0]  st0, st1;

    logic        bz, cv, dn, er;
    logic [1:0]  ct;
    logic [31:0] pt, sf;
    int          cur = 0;
    logic        mon_en = 1'b1;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    change_dispenser #(.STOCK_W(8), .STOCK_INIT(8)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .change_amt(change_amt),
        .coin_ack(coin_ack), .refill(refill), .refill_type(refill_type),
        .refill_qty(refill_qty), .busy(bz0), .coin_valid(cv0), .coin_type(ct0),
        .done(dn0), .error(er0), .paid_total(pt0), .shortfall(sf0),
        .dbg_state_o(st0)
    );

    change_dispenser #(.STOCK_W(8), .STOCK_INIT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .change_amt(change_amt),
        .coin_ack(coin_ack), .refill(1'b0), .refill_type(2'd0),
        .refill_qty(8'd0), .busy(bz1), .coin_valid(cv1), .coin_type(ct1),
        .done(dn1), .error(er1), .paid_total(pt1), .shortfall(sf1),
        .dbg_state_o(st1)
    );

    always_comb begin
        bz = (cur == 0) ? bz0 : bz1;
        cv = (cur == 0) ? cv0 : cv1;
        ct = (cur == 0) ? ct0 : ct1;
        dn = (cur == 0) ? dn0 : dn1;
        er = (cur == 0) ? er0 : er1;
        pt = (cur == 0) ? pt0 : pt1;
        sf = (cur == 0) ? sf0 : sf1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Scoreboard: every accepted coin is compared with the next expected one.
    always @(negedge clk) begin
        if (mon_en && cv && coin_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_coin actual_type=%0d expected=none", ct);
            end else begin
                chk("coin_type", 32'(ct), 32'(exp_q.pop_front()));
            end
        end
    end

    typedef struct {
        int          u;
        logic [31:0] amt;
        logic        err;
        logic [31:0] paid;
        logic [31:0] shrt;
        int          n;
        logic [1:0]  coins [10];
    } vec_t;

    vec_t vecs [7];

    task automatic start_req(input int u, input logic [31:0] amt);
        cur = u;
        @(posedge clk); #1;
        change_amt = amt;
        if (u == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic run_txn(input int u, input logic [31:0] amt, input logic err,
                           input logic [31:0] paid, input logic [31:0] shrt);
        int   k;
        int   first_cv;
        logic busy_ok;
        logic fin;
        start_req(u, amt);
        k = 0; first_cv = -1; busy_ok = 1'b1; fin = 1'b0;
        while (!fin && k < 200) begin
            @(negedge clk);
            k++;
            if (!bz) busy_ok = 1'b0;
            if (cv && first_cv < 0) first_cv = k;
            if (dn || er) fin = 1'b1;
        end
        chk("txn_finished", 32'(fin), 32'd1);
        chk("busy_during", 32'(busy_ok), 32'd1);
        if (amt == 32'd0) chk("zero_done_latency", 32'(k), 32'd2);
        else chk("first_coin_latency", 32'(first_cv), 32'd2);
        chk("error_flag", 32'(er), 32'(err));
        chk("done_flag", 32'(dn), 32'(!err));
        chk("paid_total", pt, paid);
        chk("shortfall", sf, shrt);
        @(negedge clk);
        chk("pulse_one_cycle", {29'd0, dn, er, bz}, 32'd0);
        chk("coins_all_issued", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic wait_cv();
        int   k;
        logic ok;
        k = 0; ok = 1'b0;
        while (k < 30 && !ok) begin
            @(negedge clk);
            k++;
            if (cv) ok = 1'b1;
        end
        chk("coin_presented", 32'(ok), 32'd1);
    endtask

    task automatic wait_done();
        int   k;
        logic ok;
        k = 0; ok = 1'b0;
        while (k < 30 && !ok) begin
            @(negedge clk);
            k++;
            if (dn) ok = 1'b1;
        end
        chk("done_seen", 32'(ok), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic stable;
        vecs[0] = '{0, 32'd67, 1'b0, 32'd67, 32'd0, 5, '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}};
        vecs[1] = '{0, 32'd0,  1'b0, 32'd0,  32'd0, 0, '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}};
        vecs[2] = '{0, 32'd16, 1'b0, 32'd16, 32'd0, 3, '{2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}};
        vecs[3] = '{0, 32'd49, 1'b0, 32'd49, 32'd0, 9, '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}};
        vecs[4] = '{0, 32'd3,  1'b1, 32'd1,  32'd2, 1, '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}};
        vecs[5] = '{1, 32'd60, 1'b0, 32'd60, 32'd0, 2, '{2'd3, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}};
        vecs[6] = '{1, 32'd60, 1'b1, 32'd6,  32'd54, 2, '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}};

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(bz0), 32'd0);
        chk("rst_coin_valid", 32'(cv0), 32'd0);
        chk("rst_coin_type", 32'(ct0), 32'd0);
        chk("rst_done_error", {30'd0, dn0, er0}, 32'd0);
        chk("rst_paid", pt0, 32'd0);
        chk("rst_shortfall", sf0, 32'd0);
        for (int i = 0; i < 4; i++) chk("rst_stock", 32'(dut0.stk_q[i]), 32'd8);

        // Table of payouts
        for (int i = 0; i < 7; i++) begin
            for (int c = 0; c < vecs[i].n; c++) exp_q.push_back(vecs[i].coins[c]);
            run_txn(vecs[i].u, vecs[i].amt, vecs[i].err, vecs[i].paid, vecs[i].shrt);
            if (i == 0) begin
                chk("stk1_after_67", 32'(dut0.stk_q[0]), 32'd6);
                chk("stk5_after_67", 32'(dut0.stk_q[1]), 32'd7);
                chk("stk10_after_67", 32'(dut0.stk_q[2]), 32'd7);
                chk("stk50_after_67", 32'(dut0.stk_q[3]), 32'd7);
            end
        end
        chk("stk1_after_table", 32'(dut0.stk_q[0]), 32'd0);
        chk("stk5_after_table", 32'(dut0.stk_q[1]), 32'd5);
        chk("stk10_after_table", 32'(dut0.stk_q[2]), 32'd2);
        chk("stk50_after_table", 32'(dut0.stk_q[3]), 32'd7);

        // Coin held without ack: presentation stays stable, nothing consumed
        cur = 0;
        coin_ack = 1'b0;
        start_req(0, 32'd5);
        wait_cv();
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!(cv0 && ct0 == 2'd1) || dut0.stk_q[1] != 8'd5 || pt0 != 32'd0) stable = 1'b0;
        end
        chk("hold_stable", 32'(stable), 32'd1);
        exp_q.push_back(2'd1);
        @(posedge clk); #1 coin_ack = 1'b1;
        wait_done();
        chk("hold_paid", pt0, 32'd5);
        chk("hold_stk5", 32'(dut0.stk_q[1]), 32'd4);

        // Refill on the same edge as a 1-coin is taken
        @(posedge clk); #1;
        refill = 1'b1; refill_type = 2'd0; refill_qty = 8'd1;
        @(posedge clk); #1 refill = 1'b0;
        chk("refill_one", 32'(dut0.stk_q[0]), 32'd1);
        coin_ack = 1'b0;
        start_req(0, 32'd1);
        wait_cv();
        chk("refill_coin_type", 32'(ct0), 32'd0);
        exp_q.push_back(2'd0);
        @(posedge clk); #1;
        coin_ack = 1'b1; refill = 1'b1; refill_type = 2'd0; refill_qty = 8'd3;
        @(posedge clk); #1 refill = 1'b0;
        chk("refill_with_ack", 32'(dut0.stk_q[0]), 32'd3);
        wait_done();

        // Saturating refill
        @(posedge clk); #1;
        refill = 1'b1; refill_type = 2'd3; refill_qty = 8'd243;
        @(posedge clk); #1 refill = 1'b0;
        chk("refill_to_250", 32'(dut0.stk_q[3]), 32'd250);
        @(posedge clk); #1;
        refill = 1'b1; refill_type = 2'd3; refill_qty = 8'd10;
        @(posedge clk); #1 refill = 1'b0;
        chk("refill_saturate", 32'(dut0.stk_q[3]), 32'd255);

        // Reset mid-dispense beats ack and refill
        coin_ack = 1'b0;
        start_req(0, 32'd50);
        wait_cv();
        mon_en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; coin_ack = 1'b1;
        refill = 1'b1; refill_type = 2'd3; refill_qty = 8'd5;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_coin_valid", 32'(cv0), 32'd0);
        chk("midrst_busy", 32'(bz0), 32'd0);
        chk("midrst_paid", pt0, 32'd0);
        for (int i = 0; i < 4; i++) chk("midrst_stock", 32'(dut0.stk_q[i]), 32'd8);
        @(posedge clk); #1;
        reset = 1'b0; refill = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {29'd0, bz0, cv0, dn0}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
